// File: rtl/frodo_readout_pkg.sv
// Shared definitions for the RAM readout streamer: FSM encoding, default
// output-buffer depth and the FIFO pointer-width helper.
package frodo_readout_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Pointer width for a power-of-two FIFO; a depth of 1 still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/readout_fifo.sv
// Small synchronous first-word-fall-through FIFO: the head entry is visible on
// pop_data in the same cycle it becomes non-empty.
module readout_fifo
    import frodo_readout_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PW   = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             pop_ok;

    assign pop_ok = pop && (count_q != '0);

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/mem_readout_streamer.sv
// Reads a contiguous word range from mem0 or mem1 and streams it out as
// valid/ready beats with a last marker, buffering RAM latency and backpressure.
module mem_readout_streamer
    import frodo_readout_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mem_sel,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_cnt,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = ptr_width(FIFO_DEPTH);

    state_e                state_q, state_d;
    logic                  mem_sel_q, mem_sel_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;

    logic                  issue;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  pop;
    logic [DATA_WIDTH:0]   push_word;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PW:0]           fifo_count;

    // Credit counts buffered words plus the one still in the RAM pipeline;
    // a pop in the same cycle is deliberately not credited.
    assign issue      = (state_q == READ) && ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);
    assign issue_addr = base_q + issue_cnt_q[ADDR_WIDTH-1:0];
    assign issue_last = ((issue_cnt_q + 1'b1) == cnt_q);

    // The address is presented in the issue cycle so the RAM samples it at the
    // next edge; otherwise it holds the last issued value.
    assign rd_addr    = issue ? issue_addr : addr_q;
    assign push_word  = {inflight_last_q, mem_sel_q ? rd_data1 : rd_data0};
    assign pop        = m_valid && m_ready;

    always_comb begin
        state_d         = state_q;
        mem_sel_d       = mem_sel_q;
        base_d          = base_q;
        cnt_d           = cnt_q;
        issue_cnt_d     = issue_cnt_q;
        addr_d          = issue ? issue_addr : addr_q;
        inflight_d      = issue;
        inflight_last_d = issue && issue_last;
        done_d          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (word_cnt != '0) begin
                        mem_sel_d   = mem_sel;
                        base_d      = base_addr;
                        cnt_d       = word_cnt;
                        issue_cnt_d = '0;
                        state_d     = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && (fifo_empty || (pop && fifo_count == (PW+1)'(1)))) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            mem_sel_q       <= 1'b0;
            base_q          <= '0;
            cnt_q           <= '0;
            issue_cnt_q     <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_sel_q       <= mem_sel_d;
            base_q          <= base_d;
            cnt_q           <= cnt_d;
            issue_cnt_q     <= issue_cnt_d;
            addr_q          <= addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    readout_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The credit rule must never let a returning word find the buffer full.
    assert property (@(posedge clk) disable iff (rst) !(inflight_q && fifo_full));

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign m_last  = m_valid && fifo_head[DATA_WIDTH];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule
